// File: rtl/layer_tile_scheduler_if.sv
// Handshake/config bundle between a job controller (master) and the layer tile
// scheduler (slave).
interface layer_tile_scheduler_if #(
  parameter int DIM_WIDTH = 10,
  parameter int CH_WIDTH  = 11
);
  logic                   start;
  logic                   abort;
  logic                   mem_ready;
  logic [1:0]             cfg_kernel;
  logic [CH_WIDTH-1:0]    cfg_channel;
  logic [CH_WIDTH-1:0]    cfg_filter;
  logic [DIM_WIDTH-1:0]   cfg_ifm_size;
  logic                   load_ifm;
  logic                   load_wgt;
  logic                   reset_pe;
  logic                   write_out_en;
  logic                   busy;
  logic                   done;
  logic                   cfg_err;
  logic [2*DIM_WIDTH-1:0] pix_tile;
  logic [CH_WIDTH-1:0]    flt_tile;
  logic [31:0]            perf_cycles;

  modport master (
    output start, abort, mem_ready, cfg_kernel, cfg_channel, cfg_filter, cfg_ifm_size,
    input  load_ifm, load_wgt, reset_pe, write_out_en, busy, done, cfg_err,
           pix_tile, flt_tile, perf_cycles
  );

  modport slave (
    input  start, abort, mem_ready, cfg_kernel, cfg_channel, cfg_filter, cfg_ifm_size,
    output load_ifm, load_wgt, reset_pe, write_out_en, busy, done, cfg_err,
           pix_tile, flt_tile, perf_cycles
  );
endinterface

// File: rtl/layer_tile_scheduler.sv
// Walks a conv layer tile by tile (pixel tiles inner, filter tiles outer) through
// LOAD/COMPUTE/WRITE/NEXT. Optional busy-cycle counter: define SCHED_PERF_CNT_EN.
module layer_tile_scheduler #(
  parameter int SYSTOLIC_SIZE = 16,
  parameter int DIM_WIDTH     = 10,
  parameter int CH_WIDTH      = 11
) (
  input logic                  clk,
  input logic                  rst,
  layer_tile_scheduler_if.slave bus
);
  localparam int S_LOG2 = $clog2(SYSTOLIC_SIZE);
  localparam int PW     = 2*DIM_WIDTH + 1;
  localparam int FW     = CH_WIDTH + 1;
  localparam int LW     = CH_WIDTH + 4;
  localparam int CW     = (LW > 8) ? LW : 8;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD, ST_COMPUTE, ST_WRITE, ST_NEXT, ST_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [1:0]             k_q, k_d;
  logic [CH_WIDTH-1:0]    c_q, c_d, f_q, f_d;
  logic [DIM_WIDTH-1:0]   w_q, w_d;
  logic [2*DIM_WIDTH-1:0] pix_tile_q, pix_tile_d;
  logic [CH_WIDTH-1:0]    flt_tile_q, flt_tile_d;
  logic load_q, load_d, reset_pe_q, reset_pe_d, write_q, write_d;
  logic busy_q, busy_d, done_q, done_d, cfg_err_q, cfg_err_d;
  logic accept, cfg_ok, last_pix, last_flt;

  logic [DIM_WIDTH-1:0]   ow;
  logic [PW-1:0]          pix_cnt, pt;
  logic [FW-1:0]          ft;
  logic [LW-1:0]          l_len;

  // Tile geometry from the latched config; PW/FW leave headroom for the rounding add.
  always_comb begin
    ow       = w_q - DIM_WIDTH'(k_q) + DIM_WIDTH'(1);
    pix_cnt  = PW'(ow) * PW'(ow);
    pt       = (pix_cnt + PW'(SYSTOLIC_SIZE - 1)) >> S_LOG2;
    ft       = (FW'(f_q) + FW'(SYSTOLIC_SIZE - 1)) >> S_LOG2;
    l_len    = LW'(k_q) * LW'(k_q) * LW'(c_q);
    last_pix = (PW'(pix_tile_q) == pt - PW'(1));
    last_flt = (FW'(flt_tile_q) == ft - FW'(1));
    cfg_ok   = (bus.cfg_kernel == 2'd1 || bus.cfg_kernel == 2'd3) &&
               (|bus.cfg_channel) && (|bus.cfg_filter) &&
               (bus.cfg_ifm_size >= DIM_WIDTH'(bus.cfg_kernel));
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    k_d        = k_q;
    c_d        = c_q;
    f_d        = f_q;
    w_d        = w_q;
    pix_tile_d = pix_tile_q;
    flt_tile_d = flt_tile_q;
    load_d     = 1'b0;
    cfg_err_d  = 1'b0;
    accept     = 1'b0;

    case (state_q)
      ST_IDLE: if (bus.start) begin
        if (cfg_ok) begin
          accept     = 1'b1;
          state_d    = ST_LOAD;
          k_d        = bus.cfg_kernel;
          c_d        = bus.cfg_channel;
          f_d        = bus.cfg_filter;
          w_d        = bus.cfg_ifm_size;
          pix_tile_d = '0;
          flt_tile_d = '0;
        end else begin
          cfg_err_d  = 1'b1;
        end
      end
      // cnt_q counts issued strobes; the L-th beat is the cycle its registered strobe is high.
      ST_LOAD: if (load_q && cnt_q == CW'(l_len)) begin
        state_d = ST_COMPUTE;
        cnt_d   = '0;
      end
      ST_COMPUTE: if (cnt_q == CW'(2*SYSTOLIC_SIZE - 3)) begin
        state_d = ST_WRITE;
        cnt_d   = '0;
      end else begin
        cnt_d   = cnt_q + CW'(1);
      end
      ST_WRITE: if (cnt_q == CW'(SYSTOLIC_SIZE - 1)) begin
        state_d = ST_NEXT;
        cnt_d   = '0;
      end else begin
        cnt_d   = cnt_q + CW'(1);
      end
      ST_NEXT: if (last_pix && last_flt) begin
        state_d = ST_DONE;
      end else begin
        state_d = ST_LOAD;
        if (last_pix) begin
          pix_tile_d = '0;
          flt_tile_d = flt_tile_q + CH_WIDTH'(1);
        end else begin
          pix_tile_d = pix_tile_q + (2*DIM_WIDTH)'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (bus.abort && state_q != ST_IDLE) state_d = ST_IDLE;

    if (state_d == ST_LOAD) begin
      load_d = bus.mem_ready && (state_q != ST_LOAD || cnt_q < CW'(l_len));
      cnt_d  = ((state_q == ST_LOAD) ? cnt_q : '0) + CW'(load_d);
    end
  end

  always_comb begin
    busy_d     = (state_d != ST_IDLE);
    write_d    = (state_d == ST_WRITE);
    reset_pe_d = (state_d == ST_NEXT);
    done_d     = (state_d == ST_DONE);
  end

  // NOTE: sequential state uses non-blocking assignment so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      k_q        <= '0;
      c_q        <= '0;
      f_q        <= '0;
      w_q        <= '0;
      pix_tile_q <= '0;
      flt_tile_q <= '0;
      load_q     <= 1'b0;
      reset_pe_q <= 1'b0;
      write_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      k_q        <= k_d;
      c_q        <= c_d;
      f_q        <= f_d;
      w_q        <= w_d;
      pix_tile_q <= pix_tile_d;
      flt_tile_q <= flt_tile_d;
      load_q     <= load_d;
      reset_pe_q <= reset_pe_d;
      write_q    <= write_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

`ifdef SCHED_PERF_CNT_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (accept)                  perf_d = '0;
    else if (busy_q && ~&perf_q) perf_d = perf_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) perf_q <= '0;
    else     perf_q <= perf_d;
  end

  assign bus.perf_cycles = perf_q;
`else
  assign bus.perf_cycles = '0;
`endif

  assign bus.load_ifm     = load_q;
  assign bus.load_wgt     = load_q;
  assign bus.reset_pe     = reset_pe_q;
  assign bus.write_out_en = write_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.cfg_err      = cfg_err_q;
  assign bus.pix_tile     = pix_tile_q;
  assign bus.flt_tile     = flt_tile_q;
endmodule
